// File: rtl/game_scheduler.sv
//------------------------------------------------------------------------------
// Module  : game_scheduler
// Brief   : Shares one seven-segment display and seven buttons among up to
//           four games: selection, banner, button routing and idle sleep.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module game_scheduler #(
    parameter int NUM_GAMES     = 4,
    parameter int BANNER_CYCLES = 1000,
    parameter int IDLE_CYCLES   = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   switch_pulse,
    input  logic [6:0]             btn_pulse,
    input  logic [4*NUM_GAMES-1:0] game_values,
    output logic [1:0]             game_sel,
    output logic [NUM_GAMES-1:0]   game_en,
    output logic [6:0]             btn_out,
    output logic [3:0]             display_value,
    output logic                   dp,
    output logic                   blank
);

    localparam int BW = $clog2(BANNER_CYCLES + 1);
    localparam int IW = $clog2(IDLE_CYCLES + 1);

    localparam logic [BW-1:0] c_banner_last = BW'(BANNER_CYCLES - 1);
    localparam logic [IW-1:0] c_idle_last   = IW'(IDLE_CYCLES - 1);
    localparam logic [1:0]    c_last_game   = 2'(NUM_GAMES - 1);
    localparam logic [3:0]    c_blank_code  = 4'd12;

    localparam logic [1:0] c_st_banner = 2'd0;
    localparam logic [1:0] c_st_play   = 2'd1;
    localparam logic [1:0] c_st_sleep  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    r_game_sel;
    logic [BW-1:0] r_banner_cnt;
    logic [IW-1:0] r_idle_cnt;

    logic [1:0]    w_state_nxt;
    logic [1:0]    w_game_sel_nxt;
    logic [BW-1:0] w_banner_cnt_nxt;
    logic [IW-1:0] w_idle_cnt_nxt;
    logic [1:0]    w_game_adv;
    logic          w_any_btn;
    logic [3:0]    w_play_value;

    assign w_any_btn  = |btn_pulse;
    assign w_game_adv = (r_game_sel == c_last_game) ? 2'd0 : r_game_sel + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_banner;
            r_game_sel   <= 2'd0;
            r_banner_cnt <= '0;
            r_idle_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_game_sel   <= w_game_sel_nxt;
            r_banner_cnt <= w_banner_cnt_nxt;
            r_idle_cnt   <= w_idle_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_game_sel_nxt   = r_game_sel;
        w_banner_cnt_nxt = r_banner_cnt;
        w_idle_cnt_nxt   = r_idle_cnt;
        case (r_state)
            c_st_banner: begin
                // A switch restarts the banner even on its final cycle
                if (switch_pulse) begin
                    w_game_sel_nxt   = w_game_adv;
                    w_banner_cnt_nxt = '0;
                end else if (r_banner_cnt == c_banner_last) begin
                    w_state_nxt      = c_st_play;
                    w_banner_cnt_nxt = '0;
                    w_idle_cnt_nxt   = '0;
                end else begin
                    w_banner_cnt_nxt = r_banner_cnt + BW'(1);
                end
            end
            c_st_play: begin
                if (switch_pulse) begin
                    w_game_sel_nxt   = w_game_adv;
                    w_state_nxt      = c_st_banner;
                    w_banner_cnt_nxt = '0;
                    w_idle_cnt_nxt   = '0;
                end else if (w_any_btn) begin
                    w_idle_cnt_nxt = '0;
                end else if (r_idle_cnt == c_idle_last) begin
                    w_state_nxt    = c_st_sleep;
                    w_idle_cnt_nxt = '0;
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt + IW'(1);
                end
            end
            c_st_sleep: begin
                // Waking pulse only wakes; it never advances the game
                if (switch_pulse || w_any_btn) begin
                    w_state_nxt      = c_st_banner;
                    w_banner_cnt_nxt = '0;
                    w_idle_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt      = c_st_banner;
                w_banner_cnt_nxt = '0;
                w_idle_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_play_value = 4'd0;
        game_en      = '0;
        for (int i = 0; i < NUM_GAMES; i++) begin
            if (r_game_sel == 2'(i)) begin
                w_play_value = game_values[4*i +: 4];
                game_en[i]   = 1'b1;
            end
        end
    end

    always_comb begin
        display_value = 4'd0;
        dp            = 1'b0;
        blank         = 1'b0;
        btn_out       = 7'd0;
        case (r_state)
            c_st_banner: begin
                display_value = {2'b00, r_game_sel};
                dp            = 1'b1;
            end
            c_st_play: begin
                display_value = w_play_value;
                btn_out       = switch_pulse ? 7'd0 : btn_pulse;
            end
            c_st_sleep: begin
                display_value = c_blank_code;
                blank         = 1'b1;
            end
            default: begin
                display_value = 4'd0;
            end
        endcase
    end

    assign game_sel = r_game_sel;

endmodule

`default_nettype wire

// File: doc/game_scheduler.md
# game_scheduler

Arbitration and sequencing controller that shares the single seven-segment display and the seven game buttons among up to four game datapaths (counter, dice, higher/lower, binary quiz). It owns game selection, shows a game-number banner after every switch, routes button pulses only to the active game while play is allowed, and blanks the display after an inactivity timeout. It sits between the button pulse conditioners and the game instances, and drives the sevenseg driver input.

## Interface

Parameters:
- NUM_GAMES, 4: number of attached games; legal range 2..4.
- BANNER_CYCLES, 1000: cycles the game-number banner is shown; must be ≥1.
- IDLE_CYCLES, 100000: consecutive pulse-free PLAY cycles before sleep; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- switch_pulse  in  1  one-cycle pulse, advance game.
- btn_pulse  in  7  one-cycle pulses from game buttons 1..7.
- game_values  in  4*NUM_GAMES  packed 4-bit display values; game i at [4i+3:4i].
- game_sel  out  2  index of selected game.
- game_en  out  NUM_GAMES  one-hot of game_sel, valid in every state.
- btn_out  out  7  btn_pulse forwarded to the selected game; zero unless in PLAY.
- display_value  out  4  value to sevenseg driver.
- dp  out  1  high while banner shown.
- blank  out  1  high while sleeping.

## Operation

- States: BANNER, PLAY, SLEEP. Registers: state, game_sel, banner_cnt, idle_cnt; counter widths $clog2(limit+1).
- BANNER: display_value = {2'b00, game_sel}; dp=1; btn_out=0 (pulses swallowed). banner_cnt increments each cycle; at banner_cnt == BANNER_CYCLES-1 → PLAY, banner_cnt cleared. switch_pulse in BANNER: game_sel advances, banner_cnt cleared, stay in BANNER (this has priority over expiry in the same cycle).
- PLAY: display_value = game_values slice for game_sel; dp=0; blank=0; btn_out = btn_pulse (same cycle, combinational gating). idle_cnt cleared on any switch_pulse or any btn_pulse bit, else increments; when idle_cnt == IDLE_CYCLES-1 with no pulse → SLEEP.
- switch_pulse in PLAY: game_sel advances, → BANNER, idle_cnt and banner_cnt cleared; btn_out forced to 0 in that cycle (switch wins over simultaneous buttons).
- SLEEP: display_value = 4'd12 (driver blank code); blank=1; dp=0; btn_out=0. Any switch_pulse or btn_pulse bit → BANNER with game_sel unchanged; the waking pulse is swallowed (switch does not advance).
- Game advance: game_sel+1, wraps NUM_GAMES-1 → 0.
- Game state inside each game is never reset by this block; switching away and back resumes the game's value.

## Timing

- Reset (rst_n low, asynchronous): state=BANNER, game_sel=0, game_en=one-hot bit 0, counters=0, display_value=0, dp=1, blank=0, btn_out=0.
- After rst_n deasserts, PLAY entered exactly BANNER_CYCLES rising edges later (absent switch pulses).
- State/game_sel changes visible the cycle after the triggering pulse edge; btn_out, display_value, dp, blank are combinational from registered state and current inputs (zero added latency).
- SLEEP entered after exactly IDLE_CYCLES consecutive pulse-free PLAY cycles.
- Reset mid-banner, mid-play or in sleep returns to reset values immediately; no pulse is forwarded during or after reset until PLAY.

## Test plan

- BANNER_CYCLES=4: release reset → display_value=0, dp=1 for 4 cycles, then display_value=game_values[3:0], dp=0; btn_pulse=7'h01 during banner → btn_out=0.
- In PLAY on game 0, btn_pulse=7'h02 → btn_out=7'h02 same cycle; switch_pulse 4 times → game_sel 1,2,3,0 each followed by banner showing 1,2,3,0.
- Same cycle switch_pulse=1, btn_pulse=7'h01 in PLAY → btn_out=0, game_sel+1, dp=1 next cycle.
- IDLE_CYCLES=16: 16 idle PLAY cycles → blank=1, display_value=12; btn_pulse=7'h04 → btn_out=0, BANNER with same game_sel; 15 idle cycles then pulse → no sleep.
- switch_pulse at last banner cycle → stays in BANNER, game_sel+1, banner restarts full 4 cycles.
- NUM_GAMES=3: switch from game 2 → game_sel=0; rst_n pulsed low mid-PLAY → all outputs at reset values asynchronously.
